// File: rtl/debug_frame_engine_pkg.sv
// Shared constants and state encodings for the debug frame engine
// (RX command/load decoder and TX dump serializer).
package debug_frame_engine_pkg;

  localparam logic [7:0] LOAD_CMD_DEF   = 8'h07;
  localparam logic [7:0] READY_CHAR_DEF = 8'h52;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_COUNT = 2'd1,
    RX_BYTES = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_DUMP  = 2'd1,
    TX_READY = 2'd2
  } tx_state_e;

  function automatic int num_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/debug_frame_engine_if.sv
// Byte FIFO bus between the debug engine and its RX/TX FIFOs.
// The engine is the master: it issues the pop and push strobes.
interface debug_frame_engine_if;

  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rd;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       wr;

  modport master (
    input  rx_empty, rx_data, tx_full,
    output rd, tx_data, wr
  );

  modport slave (
    output rx_empty, rx_data, tx_full,
    input  rd, tx_data, wr
  );

endinterface

// File: rtl/debug_byte_serializer.sv
// TX path: dumps a captured vector LSB byte first followed by READY_CHAR,
// and sends a standalone READY_CHAR for completed load frames.
module debug_byte_serializer
  import debug_frame_engine_pkg::*;
#(
  parameter int         DATA_W     = 129,
  parameter logic [7:0] READY_CHAR = READY_CHAR_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dump_req,
  input  logic [DATA_W-1:0] i_dump_data,
  output logic              o_dump_busy,
  input  logic              i_ready_req,
  output logic              o_ready_ack,
  input  logic              i_tx_full,
  output logic [7:0]        o_tx_data,
  output logic              o_wr
);

  localparam int NB    = num_bytes(DATA_W);
  localparam int SH_W  = NB * 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  tx_state_e        state_q, state_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic [SH_W-1:0]  dump_padded;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             load_rdy_q, load_rdy_d;
  logic             push;

  assign dump_padded = SH_W'(i_dump_data);
  assign push        = (state_q != TX_IDLE) && !i_tx_full;
  assign o_wr        = push;
  assign o_tx_data   = tx_data_q;
  assign o_dump_busy = busy_q;
  assign o_ready_ack = push && (state_q == TX_READY) && load_rdy_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= TX_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      load_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      load_rdy_q <= load_rdy_d;
    end
  end

  // tx_data_q always holds the byte on offer, so a full FIFO simply freezes it.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    load_rdy_d = load_rdy_q;
    case (state_q)
      TX_IDLE: begin
        // A pending load acknowledgement beats a simultaneous dump request.
        if (i_ready_req) begin
          state_d    = TX_READY;
          tx_data_d  = READY_CHAR;
          load_rdy_d = 1'b1;
        end else if (i_dump_req) begin
          state_d   = TX_DUMP;
          tx_data_d = dump_padded[7:0];
          shift_d   = dump_padded >> 8;
          cnt_d     = CNT_W'(NB - 1);
          busy_d    = 1'b1;
        end
      end
      TX_DUMP: begin
        if (!i_tx_full) begin
          if (cnt_q == '0) begin
            state_d    = TX_READY;
            tx_data_d  = READY_CHAR;
            load_rdy_d = 1'b0;
          end else begin
            tx_data_d = shift_q[7:0];
            shift_d   = shift_q >> 8;
            cnt_d     = cnt_q - CNT_W'(1);
          end
        end
      end
      TX_READY: begin
        if (!i_tx_full) begin
          state_d    = TX_IDLE;
          busy_d     = 1'b0;
          load_rdy_d = 1'b0;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/debug_frame_engine.sv
// Debug link engine: decodes RX bytes into commands and word-load frames,
// and serializes vector dumps plus READY acknowledgements on TX.
module debug_frame_engine
  import debug_frame_engine_pkg::*;
#(
  parameter int         DATA_W     = 129,
  parameter int         WORD_W     = 32,
  parameter logic [7:0] LOAD_CMD   = LOAD_CMD_DEF,
  parameter logic [7:0] READY_CHAR = READY_CHAR_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  debug_frame_engine_if.master bus,
  input  logic                 i_dump_req,
  input  logic [DATA_W-1:0]    i_dump_data,
  output logic                 o_dump_busy,
  output logic                 o_word_valid,
  output logic [WORD_W-1:0]    o_word,
  output logic [7:0]           o_word_idx,
  output logic                 o_load_done,
  output logic                 o_cmd_valid,
  output logic [7:0]           o_cmd
);

  localparam int BPW  = WORD_W / 8;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

  rx_state_e         rx_state_q, rx_state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]        rem_q, rem_d;
  logic [7:0]        idx_q, idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] asm_shift;
  logic [WORD_W-1:0] word_q, word_d;
  logic [7:0]        word_idx_q, word_idx_d;
  logic              word_valid_q, word_valid_d;
  logic              load_done_q, load_done_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              ready_pend_q, ready_pend_d;
  logic              ready_set, ready_ack;
  logic              last_byte, completing, pop;

  debug_byte_serializer #(
    .DATA_W     (DATA_W),
    .READY_CHAR (READY_CHAR)
  ) u_tx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_dump_req  (i_dump_req),
    .i_dump_data (i_dump_data),
    .o_dump_busy (o_dump_busy),
    .i_ready_req (ready_pend_q),
    .o_ready_ack (ready_ack),
    .i_tx_full   (bus.tx_full),
    .o_tx_data   (bus.tx_data),
    .o_wr        (bus.wr)
  );

  // Bytes shift in from the top, so the first byte lands in bits 7:0.
  assign asm_shift  = (asm_q >> 8) | (WORD_W'(bus.rx_data) << (WORD_W - 8));
  assign last_byte  = (byte_cnt_q == BC_W'(BPW - 1));
  assign completing = ((rx_state_q == RX_COUNT) && (bus.rx_data == 8'h00)) ||
                      ((rx_state_q == RX_BYTES) && last_byte && (rem_q == 8'd1));
  // Only one READY can be queued; a second frame end waits until it drains.
  assign pop    = !bus.rx_empty && !i_rst && !(completing && ready_pend_q && !ready_ack);
  assign bus.rd = pop;

  assign o_word_valid = word_valid_q;
  assign o_word       = word_q;
  assign o_word_idx   = word_idx_q;
  assign o_load_done  = load_done_q;
  assign o_cmd_valid  = cmd_valid_q;
  assign o_cmd        = cmd_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state_q   <= RX_IDLE;
      byte_cnt_q   <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      word_q       <= '0;
      word_idx_q   <= '0;
      word_valid_q <= 1'b0;
      load_done_q  <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= '0;
      ready_pend_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      byte_cnt_q   <= byte_cnt_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      word_valid_q <= word_valid_d;
      load_done_q  <= load_done_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      ready_pend_q <= ready_pend_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    byte_cnt_d   = byte_cnt_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    word_d       = word_q;
    word_idx_d   = word_idx_q;
    word_valid_d = 1'b0;
    load_done_d  = 1'b0;
    cmd_valid_d  = 1'b0;
    cmd_d        = cmd_q;
    ready_set    = 1'b0;
    if (pop) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (bus.rx_data == LOAD_CMD) begin
            rx_state_d = RX_COUNT;
          end else begin
            cmd_d       = bus.rx_data;
            cmd_valid_d = 1'b1;
          end
        end
        RX_COUNT: begin
          if (bus.rx_data == 8'h00) begin
            load_done_d = 1'b1;
            ready_set   = 1'b1;
            rx_state_d  = RX_IDLE;
          end else begin
            rem_d      = bus.rx_data;
            idx_d      = 8'h00;
            byte_cnt_d = '0;
            rx_state_d = RX_BYTES;
          end
        end
        RX_BYTES: begin
          asm_d = asm_shift;
          if (last_byte) begin
            byte_cnt_d   = '0;
            word_d       = asm_shift;
            word_valid_d = 1'b1;
            word_idx_d   = idx_q;
            idx_d        = idx_q + 8'd1;
            rem_d        = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              load_done_d = 1'b1;
              ready_set   = 1'b1;
              rx_state_d  = RX_IDLE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
    ready_pend_d = (ready_pend_q && !ready_ack) || ready_set;
  end

endmodule

// File: tb/tb_debug_frame_engine.sv
// Directed bench for debug_frame_engine: RX FIFO model feeds byte streams,
// TX/word/command activity is logged and compared against hand-built tables.
module tb_debug_frame_engine;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_dump_req;
  logic [128:0]  i_dump_data;
  logic          o_dump_busy;
  logic          o_word_valid;
  logic [31:0]   o_word;
  logic [7:0]    o_word_idx;
  logic          o_load_done;
  logic          o_cmd_valid;
  logic [7:0]    o_cmd;

  debug_frame_engine_if bus();

  debug_frame_engine #(
    .DATA_W (129),
    .WORD_W (32)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .bus          (bus),
    .i_dump_req   (i_dump_req),
    .i_dump_data  (i_dump_data),
    .o_dump_busy  (o_dump_busy),
    .o_word_valid (o_word_valid),
    .o_word       (o_word),
    .o_word_idx   (o_word_idx),
    .o_load_done  (o_load_done),
    .o_cmd_valid  (o_cmd_valid),
    .o_cmd        (o_cmd)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  logic        tx_busy_log[$];
  logic [40:0] word_log[$];
  logic [7:0]  cmd_log[$];
  int          ld_cnt;

  // First-word-fall-through RX FIFO: head updates after each clock.
  always @(posedge i_clk) begin
    if (bus.rd && rx_q.size() > 0) void'(rx_q.pop_front());
    bus.rx_empty <= (rx_q.size() == 0);
    bus.rx_data  <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  always @(negedge i_clk) begin
    if (bus.wr) begin
      tx_log.push_back(bus.tx_data);
      tx_busy_log.push_back(o_dump_busy);
    end
    if (o_word_valid) word_log.push_back({o_word_idx, o_word, o_load_done});
    if (o_load_done) ld_cnt++;
    if (o_cmd_valid) cmd_log.push_back(o_cmd);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s = %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    tx_log.delete();
    tx_busy_log.delete();
    word_log.delete();
    cmd_log.delete();
    ld_cnt = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic start_dump(input logic [128:0] d);
    @(posedge i_clk); #1;
    i_dump_data = d;
    i_dump_req  = 1'b1;
    @(posedge i_clk); #1;
    i_dump_req  = 1'b0;
    i_dump_data = ~d;
  endtask

  task automatic wait_not_busy(input string tag);
    int k = 0;
    while (o_dump_busy && k < 300) begin
      @(posedge i_clk); #1;
      k++;
    end
    check(tag, 64'(k < 300), 64'd1);
  endtask

  function automatic logic [7:0] vbyte(input logic [128:0] v, input int i);
    logic [135:0] p;
    p = {7'd0, v};
    return p[8*i +: 8];
  endfunction

  function automatic logic [63:0] tx_at(input int i);
    return (i < tx_log.size()) ? 64'(tx_log[i]) : 64'hDEAD;
  endfunction

  task automatic check_dump_bytes(input string tag, input logic [128:0] v, input int base);
    for (int i = 0; i < 17; i++)
      check($sformatf("%s_b%0d", tag, i), tx_at(base + i), 64'(vbyte(v, i)));
  endtask

  localparam logic [128:0] V1 = {1'b1, 128'h0123456789ABCDEF0123456789ABCDEF};
  localparam logic [128:0] V2 = {1'b0, 128'h00112233445566778899AABBCCDDEEFF};
  localparam logic [128:0] V3 = {1'b1, 128'hFEDCBA98765432100F1E2D3C4B5A6978};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] load_seq[10];
    logic [7:0] held;
    int stall_wr, stall_chg, k;
    bit all_busy;

    i_rst       = 1'b1;
    i_dump_req  = 1'b0;
    i_dump_data = '0;
    bus.tx_full = 1'b0;
    ld_cnt      = 0;
    cycles(3);

    // Reset state
    check("rst_strobes", 64'({bus.rd, bus.wr, o_word_valid, o_load_done, o_cmd_valid, o_dump_busy}), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_word", 64'({o_word, o_word_idx}), 64'd0);
    check("rst_cmd", 64'(o_cmd), 64'd0);
    i_rst = 1'b0;
    cycles(2);

    // Plain commands, no TX activity
    clear_logs();
    rx_q.push_back(8'h0B);
    rx_q.push_back(8'h02);
    cycles(10);
    check("cmd_count", 64'(cmd_log.size()), 64'd2);
    check("cmd_0", (cmd_log.size() > 0) ? 64'(cmd_log[0]) : 64'hDEAD, 64'h0B);
    check("cmd_1", (cmd_log.size() > 1) ? 64'(cmd_log[1]) : 64'hDEAD, 64'h02);
    check("cmd_no_tx", 64'(tx_log.size()), 64'd0);

    // Two-word load frame
    clear_logs();
    load_seq = '{8'h07, 8'h02, 8'h01, 8'h00, 8'h00, 8'h3C, 8'h03, 8'h00, 8'h03, 8'h3C};
    foreach (load_seq[i]) rx_q.push_back(load_seq[i]);
    cycles(25);
    check("load_words", 64'(word_log.size()), 64'd2);
    check("load_w0", (word_log.size() > 0) ? 64'(word_log[0]) : 64'hDEAD, 64'({8'd0, 32'h3C000001, 1'b0}));
    check("load_w1", (word_log.size() > 1) ? 64'(word_log[1]) : 64'hDEAD, 64'({8'd1, 32'h3C030003, 1'b1}));
    check("load_done_cnt", 64'(ld_cnt), 64'd1);
    check("load_tx_cnt", 64'(tx_log.size()), 64'd1);
    check("load_tx_ready", tx_at(0), 64'h52);
    check("load_no_cmd", 64'(cmd_log.size()), 64'd0);

    // 129-bit dump, data changed right after capture
    clear_logs();
    start_dump(V1);
    check("dump1_busy_rise", 64'(o_dump_busy), 64'd1);
    wait_not_busy("dump1_done");
    cycles(3);
    check("dump1_tx_cnt", 64'(tx_log.size()), 64'd18);
    check_dump_bytes("dump1", V1, 0);
    check("dump1_ready", tx_at(17), 64'h52);
    all_busy = 1'b1;
    foreach (tx_busy_log[i]) if (!tx_busy_log[i]) all_busy = 1'b0;
    check("dump1_busy_all", 64'(all_busy), 64'd1);
    check("dump1_busy_end", 64'(o_dump_busy), 64'd0);

    // Back-pressure for 20 cycles mid-dump
    clear_logs();
    start_dump(V2);
    k = 0;
    while (tx_log.size() < 5 && k < 200) begin
      @(negedge i_clk); #1;
      k++;
    end
    check("stall_reach", 64'(k < 200), 64'd1);
    @(posedge i_clk); #1;
    bus.tx_full = 1'b1;
    held      = bus.tx_data;
    stall_wr  = 0;
    stall_chg = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (bus.wr) stall_wr++;
      if (bus.tx_data !== held) stall_chg++;
    end
    @(posedge i_clk); #1;
    bus.tx_full = 1'b0;
    check("stall_no_wr", 64'(stall_wr), 64'd0);
    check("stall_hold", 64'(stall_chg), 64'd0);
    check("stall_held_byte", 64'(held), 64'(vbyte(V2, 5)));
    wait_not_busy("dump2_done");
    cycles(3);
    check("dump2_tx_cnt", 64'(tx_log.size()), 64'd18);
    check_dump_bytes("dump2", V2, 0);
    check("dump2_ready", tx_at(17), 64'h52);

    // Load frame ends during a dump; repeated requests ignored
    clear_logs();
    start_dump(V3);
    rx_q.push_back(8'h07);
    rx_q.push_back(8'h00);
    for (int r = 0; r < 3; r++) begin
      @(posedge i_clk); #1;
      check($sformatf("rereq_busy_%0d", r), 64'(o_dump_busy), 64'd1);
      i_dump_req = 1'b1;
      @(posedge i_clk); #1;
      i_dump_req = 1'b0;
    end
    wait_not_busy("dump3_done");
    cycles(8);
    check("dump3_tx_cnt", 64'(tx_log.size()), 64'd19);
    check_dump_bytes("dump3", V3, 0);
    check("dump3_ready", tx_at(17), 64'h52);
    check("dump3_load_ready", tx_at(18), 64'h52);
    check("dump3_load_done", 64'(ld_cnt), 64'd1);

    // Reset in the middle of a word, then an empty load frame
    clear_logs();
    rx_q.push_back(8'h07);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'hAA);
    rx_q.push_back(8'hBB);
    cycles(8);
    i_rst = 1'b1;
    #1;
    check("mid_rst_strobes", 64'({bus.rd, bus.wr, o_word_valid, o_load_done, o_cmd_valid, o_dump_busy}), 64'd0);
    check("mid_rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("mid_rst_word", 64'({o_word, o_word_idx}), 64'd0);
    check("mid_rst_cmd", 64'(o_cmd), 64'd0);
    cycles(2);
    i_rst = 1'b0;
    cycles(2);
    clear_logs();
    rx_q.push_back(8'h07);
    rx_q.push_back(8'h00);
    cycles(10);
    check("post_rst_words", 64'(word_log.size()), 64'd0);
    check("post_rst_cmds", 64'(cmd_log.size()), 64'd0);
    check("post_rst_done", 64'(ld_cnt), 64'd1);
    check("post_rst_tx_cnt", 64'(tx_log.size()), 64'd1);
    check("post_rst_ready", tx_at(0), 64'h52);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
